// File: rtl/pci_pkg.sv
// Shared command codes, state encoding and limits for the PCI burst target.
package pci_pkg;

  localparam logic [3:0] PCI_CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] PCI_CMD_MEM_WRITE = 4'b0111;
  localparam int         PCI_MAX_INIT_WAIT = 13;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, DISC, TURN} pci_tgt_state_t;

  function automatic logic pci_cmd_supported(input logic [3:0] cmd);
    return (cmd == PCI_CMD_MEM_READ) || (cmd == PCI_CMD_MEM_WRITE);
  endfunction

endpackage

// File: rtl/pci_target_mem.sv
// Local word store for the burst target: byte-enabled synchronous write,
// asynchronous read from the same index.
module pci_target_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pci_burst_target.sv
// PCI memory target: window decode, initial wait states, burst transfer and
// STOP# disconnect at the window end, with turnaround drive before release.
module pci_burst_target
  import pci_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  inout  wire         DEVSEL,
  inout  wire         TRDY,
  inout  wire         STOP,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > PCI_MAX_INIT_WAIT) begin : g_bad_ws
    $error("pci_burst_target: WAIT_STATES out of range");
  end
  if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pci_burst_target: DEPTH must be a power of two in 2..1024");
  end
  if (BASE_ADDR[AW+1:0] != '0) begin : g_bad_base
    $error("pci_burst_target: BASE_ADDR not aligned to window size");
  end

  pci_tgt_state_t state;
  logic [AW-1:0]  idx;
  logic [3:0]     cnt;
  logic           is_read, devsel_q, trdy_q, stop_q, ad_oe;
  logic           frame_q, skip, rst_done;
  logic [3:0]     we;
  logic [31:0]    rdata;

  logic addr_phase, hit, rd_cmd, xfer, abandon;

  // rst_done delays recognition until the second edge after reset release.
  assign addr_phase = (state == IDLE) && rst_done && !FRAME && frame_q && !skip;
  assign hit        = (AD[31:AW+2] == BASE_ADDR[31:AW+2]) && (AD[1:0] == 2'b00) &&
                      pci_cmd_supported(CBE);
  assign rd_cmd     = (CBE == PCI_CMD_MEM_READ);
  assign xfer       = (state == DATA) && !IRDY && !trdy_q;
  assign abandon    = FRAME && IRDY;
  assign we         = {4{xfer && !is_read}} & ~CBE;

  pci_target_mem #(.DEPTH(DEPTH)) u_mem (
    .CLK   (CLK),
    .we    (we),
    .addr  (idx),
    .wdata (AD),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      is_read  <= 1'b0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      ad_oe    <= 1'b0;
      frame_q  <= 1'b1;
      skip     <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      frame_q  <= FRAME;
      case (state)
        IDLE: begin
          if (abandon) skip <= 1'b0;
          if (addr_phase) begin
            if (hit) begin
              idx      <= AD[AW+1:2];
              is_read  <= rd_cmd;
              devsel_q <= 1'b0;
              // Zero-wait writes skip WAIT; reads always need one turnaround clock.
              if (!rd_cmd && WAIT_STATES == 0) begin
                state  <= DATA;
                trdy_q <= 1'b0;
              end else begin
                state <= WAIT;
                cnt   <= rd_cmd ? WS : WS - 4'd1;
              end
            end else begin
              skip <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (abandon) begin
            state    <= TURN;
            devsel_q <= 1'b1;
          end else if (cnt == 4'd0) begin
            state  <= DATA;
            trdy_q <= 1'b0;
            ad_oe  <= is_read;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DATA: begin
          if (xfer) begin
            idx <= idx + 1'b1;
            if (FRAME) begin
              state    <= TURN;
              devsel_q <= 1'b1;
              trdy_q   <= 1'b1;
              ad_oe    <= 1'b0;
            end else if (idx == AW'(DEPTH - 1)) begin
              state  <= DISC;
              trdy_q <= 1'b1;
              stop_q <= 1'b0;
              ad_oe  <= 1'b0;
            end
          end else if (abandon) begin
            state    <= TURN;
            devsel_q <= 1'b1;
            trdy_q   <= 1'b1;
            ad_oe    <= 1'b0;
          end
        end
        DISC: begin
          if (FRAME) begin
            state    <= TURN;
            devsel_q <= 1'b1;
            stop_q   <= 1'b1;
          end
        end
        TURN: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control lines are driven in every non-idle state, high during TURN.
  assign busy   = (state != IDLE);
  assign DEVSEL = busy ? devsel_q : 1'bz;
  assign TRDY   = busy ? trdy_q   : 1'bz;
  assign STOP   = busy ? stop_q   : 1'bz;
  assign AD     = ad_oe ? rdata : 32'bz;

endmodule

// File: tb/tb_pci_burst_target.sv
// Directed bench: a zero-wait target at 0x100 and a three-wait target at 0x200
// share the initiator signals; released control lines read high via pullups.
module tb_pci_burst_target;
  import pci_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FRAME = 1'b1;
  logic        IRDY = 1'b1;
  logic [3:0]  CBE = 4'hF;
  logic [31:0] ad_drv = '0;
  logic        ad_en = 1'b0;
  wire  [31:0] AD0, AD3;
  wire         DEVSEL0, TRDY0, STOP0, DEVSEL3, TRDY3, STOP3;
  logic        busy0, busy3;
  int          vec = 0;
  int          errs = 0;

  assign AD0 = ad_en ? ad_drv : 32'bz;
  assign AD3 = ad_en ? ad_drv : 32'bz;
  pullup (DEVSEL0);
  pullup (TRDY0);
  pullup (STOP0);
  pullup (DEVSEL3);
  pullup (TRDY3);
  pullup (STOP3);

  always #5 CLK = ~CLK;

  pci_burst_target #(.DEPTH(16), .BASE_ADDR(32'h0000_0100), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(RST), .FRAME(FRAME), .IRDY(IRDY), .CBE(CBE),
    .AD(AD0), .DEVSEL(DEVSEL0), .TRDY(TRDY0), .STOP(STOP0), .busy(busy0));

  pci_burst_target #(.DEPTH(16), .BASE_ADDR(32'h0000_0200), .WAIT_STATES(3)) dut3 (
    .CLK(CLK), .RST(RST), .FRAME(FRAME), .IRDY(IRDY), .CBE(CBE),
    .AD(AD3), .DEVSEL(DEVSEL3), .TRDY(TRDY3), .STOP(STOP3), .busy(busy3));

  function automatic logic trdy_of(input bit s);
    return s ? TRDY3 : TRDY0;
  endfunction

  function automatic logic [31:0] ad_of(input bit s);
    return s ? AD3 : AD0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
    FRAME = 1'b0; IRDY = 1'b1; CBE = cmd; ad_drv = a; ad_en = 1'b1;
    tick();
  endtask

  task automatic wr_burst(input bit s, input logic [31:0] a, input int n,
                          input logic [3:0][31:0] d, input logic [3:0][3:0] be,
                          output int waits, output bit ok);
    int g;
    waits = 0; ok = 1'b1;
    addr_phase(a, PCI_CMD_MEM_WRITE);
    for (int i = 0; i < n; i++) begin
      ad_drv = d[i]; CBE = be[i]; IRDY = 1'b0; FRAME = (i == n - 1);
      g = 0;
      while (trdy_of(s) !== 1'b0 && g < 32) begin tick(); g++; waits++; end
      if (g == 32) ok = 1'b0;
      tick();
    end
    FRAME = 1'b1; IRDY = 1'b1; ad_en = 1'b0; CBE = 4'hF;
    tick();
  endtask

  task automatic rd_burst(input bit s, input logic [31:0] a, input int n,
                          output logic [3:0][31:0] d, output int waits, output bit ok);
    int g;
    waits = 0; ok = 1'b1; d = '0;
    addr_phase(a, PCI_CMD_MEM_READ);
    ad_en = 1'b0; CBE = 4'h0; IRDY = 1'b0;
    for (int i = 0; i < n; i++) begin
      FRAME = (i == n - 1);
      g = 0;
      while (trdy_of(s) !== 1'b0 && g < 32) begin tick(); g++; waits++; end
      if (g == 32) ok = 1'b0;
      d[i] = ad_of(s);
      tick();
    end
    FRAME = 1'b1; IRDY = 1'b1; CBE = 4'hF;
    tick();
  endtask

  task automatic test_reset();
    #2;
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    vec++; if (busy3 !== 1'b0) begin errs++; $display("FAIL reset_busy3: got %b want 0", busy3); end
    vec++; if ({DEVSEL0, TRDY0, STOP0} !== 3'b111) begin errs++; $display("FAIL reset_lines: got %b want 111 (released)", {DEVSEL0, TRDY0, STOP0}); end
    tick(); tick();
    RST = 1'b1;
    tick(); tick();
  endtask

  task automatic test_write_read();
    addr_phase(32'h108, PCI_CMD_MEM_WRITE);
    vec++; if (DEVSEL0 !== 1'b0) begin errs++; $display("FAIL wr_devsel_n: got %b want 0", DEVSEL0); end
    vec++; if (TRDY0 !== 1'b0) begin errs++; $display("FAIL wr_trdy_n: got %b want 0", TRDY0); end
    ad_drv = 32'hDEADBEEF; CBE = 4'h0; IRDY = 1'b0; FRAME = 1'b1;
    tick();
    vec++; if ({busy0, DEVSEL0, TRDY0} !== 3'b111) begin errs++; $display("FAIL wr_turn: got %b want 111", {busy0, DEVSEL0, TRDY0}); end
    IRDY = 1'b1; ad_en = 1'b0; CBE = 4'hF;
    tick();
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL wr_idle: got %b want 0", busy0); end
    addr_phase(32'h108, PCI_CMD_MEM_READ);
    vec++; if ({DEVSEL0, TRDY0} !== 2'b01) begin errs++; $display("FAIL rd_wait: got %b want 01", {DEVSEL0, TRDY0}); end
    ad_en = 1'b0; CBE = 4'h0; IRDY = 1'b0; FRAME = 1'b1;
    tick();
    vec++; if (TRDY0 !== 1'b0) begin errs++; $display("FAIL rd_trdy_n1: got %b want 0", TRDY0); end
    vec++; if (AD0 !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_data: got %h want deadbeef", AD0); end
    tick();
    vec++; if ({busy0, DEVSEL0, TRDY0} !== 3'b111) begin errs++; $display("FAIL rd_turn: got %b want 111", {busy0, DEVSEL0, TRDY0}); end
    IRDY = 1'b1; CBE = 4'hF;
    tick();
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rd_idle: got %b want 0", busy0); end
  endtask

  task automatic test_byte_enables();
    logic [3:0][31:0] d, q;
    logic [3:0][3:0]  be;
    int w; bit ok;
    d = '0; be = '0;
    d[0] = 32'h11223344; be[0] = 4'h0;
    wr_burst(1'b0, 32'h10C, 1, d, be, w, ok);
    d[0] = 32'hAABBCCDD; be[0] = 4'b1010;
    wr_burst(1'b0, 32'h10C, 1, d, be, w, ok);
    rd_burst(1'b0, 32'h10C, 1, q, w, ok);
    vec++; if (q[0] !== 32'h11BB33DD) begin errs++; $display("FAIL byte_en: got %h want 11bb33dd", q[0]); end
    vec++; if (ok !== 1'b1) begin errs++; $display("FAIL byte_en_timeout: got %b want 1", ok); end
  endtask

  task automatic test_miss();
    logic [3:0][31:0] d, q;
    logic [3:0][3:0]  be;
    int w; bit ok;
    d = '0; be = '0;
    d[0] = 32'h0BADCAFE;
    wr_burst(1'b0, 32'h100, 1, d, be, w, ok);
    addr_phase(32'h140, PCI_CMD_MEM_WRITE);
    ad_drv = 32'h12345678; CBE = 4'h0; IRDY = 1'b0; FRAME = 1'b1;
    vec++; if ({busy0, busy3} !== 2'b00) begin errs++; $display("FAIL miss_busy: got %b want 00", {busy0, busy3}); end
    tick();
    vec++; if ({DEVSEL0, TRDY0, STOP0} !== 3'b111) begin errs++; $display("FAIL miss_lines: got %b want 111", {DEVSEL0, TRDY0, STOP0}); end
    IRDY = 1'b1; ad_en = 1'b0; CBE = 4'hF;
    tick();
    addr_phase(32'h108, 4'b0010);
    ad_en = 1'b0; CBE = 4'h0; IRDY = 1'b0; FRAME = 1'b1;
    vec++; if ({busy0, DEVSEL0} !== 2'b01) begin errs++; $display("FAIL miss_cmd: got %b want 01", {busy0, DEVSEL0}); end
    tick();
    IRDY = 1'b1; CBE = 4'hF;
    tick();
    rd_burst(1'b0, 32'h100, 1, q, w, ok);
    vec++; if (q[0] !== 32'h0BADCAFE) begin errs++; $display("FAIL miss_mem0: got %h want 0badcafe", q[0]); end
    rd_burst(1'b0, 32'h108, 1, q, w, ok);
    vec++; if (q[0] !== 32'hDEADBEEF) begin errs++; $display("FAIL miss_mem2: got %h want deadbeef", q[0]); end
  endtask

  task automatic test_wait_states();
    logic [3:0][31:0] d;
    logic [3:0][3:0]  be;
    int w; bit ok;
    d = '0; be = '0;
    d[0] = 32'hCAFEF00D;
    wr_burst(1'b1, 32'h204, 1, d, be, w, ok);
    vec++; if (w !== 3) begin errs++; $display("FAIL ws_write_waits: got %0d want 3", w); end
    addr_phase(32'h204, PCI_CMD_MEM_READ);
    ad_en = 1'b0; CBE = 4'h0; IRDY = 1'b0; FRAME = 1'b1;
    vec++; if ({DEVSEL3, TRDY3, busy0} !== 3'b010) begin errs++; $display("FAIL ws_n: got %b want 010", {DEVSEL3, TRDY3, busy0}); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      vec++; if ({DEVSEL3, TRDY3, STOP3} !== 3'b011) begin errs++; $display("FAIL ws_wait%0d: got %b want 011", k, {DEVSEL3, TRDY3, STOP3}); end
    end
    tick();
    vec++; if (TRDY3 !== 1'b0) begin errs++; $display("FAIL ws_trdy_n4: got %b want 0", TRDY3); end
    vec++; if (AD3 !== 32'hCAFEF00D) begin errs++; $display("FAIL ws_data_n4: got %h want cafef00d", AD3); end
    tick();
    IRDY = 1'b1; CBE = 4'hF;
    tick();
    vec++; if (busy3 !== 1'b0) begin errs++; $display("FAIL ws_idle: got %b want 0", busy3); end
  endtask

  task automatic test_disconnect();
    logic [3:0][31:0] q;
    int w; bit ok;
    addr_phase(32'h138, PCI_CMD_MEM_WRITE);
    IRDY = 1'b0; CBE = 4'h0; FRAME = 1'b0; ad_drv = 32'hA0A0_0014;
    tick();
    vec++; if ({TRDY0, STOP0} !== 2'b01) begin errs++; $display("FAIL disc_first: got %b want 01", {TRDY0, STOP0}); end
    ad_drv = 32'hA0A0_0015;
    tick();
    vec++; if ({DEVSEL0, TRDY0, STOP0} !== 3'b010) begin errs++; $display("FAIL disc_stop: got %b want 010", {DEVSEL0, TRDY0, STOP0}); end
    ad_drv = 32'hA0A0_0016;
    tick();
    vec++; if ({DEVSEL0, TRDY0, STOP0} !== 3'b010) begin errs++; $display("FAIL disc_hold: got %b want 010", {DEVSEL0, TRDY0, STOP0}); end
    FRAME = 1'b1;
    tick();
    vec++; if ({busy0, DEVSEL0, TRDY0, STOP0} !== 4'b1111) begin errs++; $display("FAIL disc_turn: got %b want 1111", {busy0, DEVSEL0, TRDY0, STOP0}); end
    IRDY = 1'b1; ad_en = 1'b0; CBE = 4'hF;
    tick();
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL disc_idle: got %b want 0", busy0); end
    rd_burst(1'b0, 32'h138, 2, q, w, ok);
    vec++; if ({q[1], q[0]} !== {32'hA0A0_0015, 32'hA0A0_0014}) begin errs++; $display("FAIL disc_data: got %h %h want a0a00015 a0a00014", q[1], q[0]); end
    rd_burst(1'b0, 32'h100, 1, q, w, ok);
    vec++; if (q[0] !== 32'h0BADCAFE) begin errs++; $display("FAIL disc_nowrap: got %h want 0badcafe", q[0]); end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0][31:0] d, q;
    logic [3:0][3:0]  be;
    int w; bit ok;
    d = '0; be = '0;
    addr_phase(32'h100, PCI_CMD_MEM_WRITE);
    IRDY = 1'b0; CBE = 4'h0; ad_drv = 32'h5000_0000;
    tick();
    ad_drv = 32'h5000_0001;
    tick();
    ad_drv = 32'h5000_0002;
    #2 RST = 1'b0;
    #1;
    vec++; if ({busy0, DEVSEL0, TRDY0, STOP0} !== 4'b0111) begin errs++; $display("FAIL rst_mid: got %b want 0111", {busy0, DEVSEL0, TRDY0, STOP0}); end
    FRAME = 1'b1; IRDY = 1'b1; ad_en = 1'b0; CBE = 4'hF;
    tick(); tick();
    RST = 1'b1;
    addr_phase(32'h100, PCI_CMD_MEM_WRITE);
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rst_sync_edge1: got %b want 0", busy0); end
    FRAME = 1'b1; ad_en = 1'b0; CBE = 4'hF;
    tick();
    d[0] = 32'h600DF00D;
    wr_burst(1'b0, 32'h100, 1, d, be, w, ok);
    vec++; if (ok !== 1'b1) begin errs++; $display("FAIL rst_new_write: got %b want 1", ok); end
    rd_burst(1'b0, 32'h100, 3, q, w, ok);
    vec++; if (q[0] !== 32'h600DF00D) begin errs++; $display("FAIL rst_new_data: got %h want 600df00d", q[0]); end
    vec++; if (q[1] !== 32'h5000_0001) begin errs++; $display("FAIL rst_retained: got %h want 50000001", q[1]); end
    vec++; if (q[2] !== 32'hDEADBEEF) begin errs++; $display("FAIL rst_third_dropped: got %h want deadbeef", q[2]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0][31:0] d, q;
    logic [3:0][3:0]  be;
    int w; bit ok;
    be = '0;
    d[0] = 32'h4444_0004; d[1] = 32'h5555_0005; d[2] = 32'h6666_0006; d[3] = '0;
    wr_burst(1'b0, 32'h110, 3, d, be, w, ok);
    vec++; if (w !== 0) begin errs++; $display("FAIL b2b_write_waits: got %0d want 0", w); end
    rd_burst(1'b0, 32'h110, 3, q, w, ok);
    vec++; if (w !== 1) begin errs++; $display("FAIL b2b_read_waits: got %0d want 1", w); end
    vec++; if (q[2:0] !== d[2:0]) begin errs++; $display("FAIL b2b_data: got %h want %h", q[2:0], d[2:0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_miss();
    test_wait_states();
    test_disconnect();
    test_reset_mid_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
